// File: rtl/modport_fifo_pkg.sv
// Shared defaults and data type for the write-beat FIFO.
// No ports; imported by the interface, storage array and top.
package fifo_pkg;
   localparam int DATA_W_DEF = 128;
   localparam int DEPTH_DEF  = 16;
   typedef logic [DATA_W_DEF-1:0] fifo_data_t;
endpackage

// File: rtl/modport_fifo_if.sv
// Push/pop bundle between producer, FIFO and consumer.
// master drives wr_en/wr_data/rd_en; slave returns data and status.
interface modport_fifo_if
   import fifo_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF
);
   localparam int ADDR_W = $clog2(DEPTH);

   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic              rd_en;
   logic [DATA_W-1:0] rd_data;
   logic              full;
   logic              empty;
   logic [ADDR_W:0]   count;
   logic              overflow;
   logic              underflow;

   modport master (
      output wr_en, wr_data, rd_en,
      input  rd_data, full, empty, count, overflow, underflow
   );

   modport slave (
      input  wr_en, wr_data, rd_en,
      output rd_data, full, empty, count, overflow, underflow
   );
endinterface

// File: rtl/modport_fifo_mem.sv
// Register array: one write port, one registered read port.
// Ports: clk, rst (sync active-low, clears rdata only), we/waddr/wdata, re/raddr/rdata.
module fifo_mem
   import fifo_pkg::*;
#(
   parameter  int DATA_W = DATA_W_DEF,
   parameter  int DEPTH  = DEPTH_DEF,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [DEPTH];

   // Storage is deliberately never cleared.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (!rst)    rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/modport_fifo.sv
// Single-clock FIFO with registered status and one-cycle read latency.
// Ports: clk, rst (sync active-low), bus (slave side of modport_fifo_if).
module modport_fifo
   import fifo_pkg::*;
#(
   parameter  int DATA_W = DATA_W_DEF,
   parameter  int DEPTH  = DEPTH_DEF,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input logic           clk,
   input logic           rst,
   modport_fifo_if.slave bus
);
   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   count_q;
   logic [ADDR_W:0]   count_nxt;
   logic              full_q;
   logic              empty_q;
   logic              ovf_q;
   logic              udf_q;
   logic              rd_acc;
   logic              wr_acc;

   // A push while full is admitted only when a pop frees a slot.
   assign rd_acc = bus.rd_en & ~empty_q;
   assign wr_acc = bus.wr_en & (~full_q | rd_acc);

   always_comb begin
      count_nxt = count_q;
      if (wr_acc && !rd_acc)      count_nxt = count_q + 1'b1;
      else if (rd_acc && !wr_acc) count_nxt = count_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + ADDR_W'(1);
         if (rd_acc) rd_ptr <= rd_ptr + ADDR_W'(1);
         count_q <= count_nxt;
         full_q  <= (count_nxt == FULL_CNT);
         empty_q <= (count_nxt == '0);
         ovf_q   <= bus.wr_en & ~wr_acc;
         udf_q   <= bus.rd_en & empty_q;
      end
   end

   // Gating with rst keeps stray enables during reset out of the array.
   fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_acc & rst),
      .waddr (wr_ptr),
      .wdata (bus.wr_data),
      .re    (rd_acc & rst),
      .raddr (rd_ptr),
      .rdata (bus.rd_data)
   );

   assign bus.full      = full_q;
   assign bus.empty     = empty_q;
   assign bus.count     = count_q;
   assign bus.overflow  = ovf_q;
   assign bus.underflow = udf_q;
endmodule

// File: tb/tb_modport_fifo.sv
// Testbench for modport_fifo: directed table, corner sequences, random vs queue model.
// No ports.
module tb_modport_fifo;
   import fifo_pkg::*;

   localparam int DEPTH = 16;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   modport_fifo_if #(.DATA_W(DATA_W_DEF), .DEPTH(DEPTH)) bus ();

   modport_fifo #(.DATA_W(DATA_W_DEF), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   fifo_data_t mq[$];
   fifo_data_t m_rd;
   bit         m_ovf;
   bit         m_udf;

   typedef struct {
      bit         we;
      bit         re;
      fifo_data_t wd;
      fifo_data_t rd;
      int         cnt;
      bit         emp;
      bit         ful;
      bit         ovf;
      bit         udf;
   } vec_t;

   vec_t tbl [7];

   task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cyc(bit rn, bit we, bit re, fifo_data_t wd);
      bit rd_ok, wr_ok;
      rst         = rn;
      bus.wr_en   = we;
      bus.rd_en   = re;
      bus.wr_data = wd;
      @(posedge clk);
      #1;
      if (!rn) begin
         mq.delete();
         m_rd  = '0;
         m_ovf = 0;
         m_udf = 0;
      end else begin
         rd_ok = re && (mq.size() > 0);
         wr_ok = we && ((mq.size() < DEPTH) || rd_ok);
         m_ovf = we && !wr_ok;
         m_udf = re && (mq.size() == 0);
         if (rd_ok) m_rd = mq.pop_front();
         if (wr_ok) mq.push_back(wd);
      end
      chk("count",     128'(bus.count),     128'(mq.size()));
      chk("empty",     128'(bus.empty),     128'(mq.size() == 0));
      chk("full",      128'(bus.full),      128'(mq.size() == DEPTH));
      chk("rd_data",   bus.rd_data,         m_rd);
      chk("overflow",  128'(bus.overflow),  128'(m_ovf));
      chk("underflow", 128'(bus.underflow), 128'(m_udf));
   endtask

   initial begin
      int wp, rp;
      fifo_data_t dead = 128'hDEAD_BEEF_0000_0001;

      tbl[0] = '{1, 0, dead,    '0,   1, 0, 0, 0, 0};
      tbl[1] = '{0, 1, '0,      dead, 0, 1, 0, 0, 0};
      tbl[2] = '{0, 1, '0,      dead, 0, 1, 0, 0, 1};
      tbl[3] = '{0, 0, '0,      dead, 0, 1, 0, 0, 0};
      tbl[4] = '{1, 1, 128'h2,  dead, 1, 0, 0, 0, 1};
      tbl[5] = '{1, 1, 128'h3,  128'h2, 1, 0, 0, 0, 0};
      tbl[6] = '{0, 1, '0,      128'h3, 0, 1, 0, 0, 0};

      // Reset with enables asserted: they must be ignored.
      cyc(0, 1, 1, 128'h55);
      cyc(0, 1, 1, 128'h66);
      for (int i = 0; i < 3; i++) begin
         cyc(1, 0, 0, '0);
         chk("idle_empty", 128'(bus.empty), 128'h1);
         chk("idle_rd",    bus.rd_data,     128'h0);
      end

      for (int i = 0; i < 7; i++) begin
         cyc(1, tbl[i].we, tbl[i].re, tbl[i].wd);
         chk($sformatf("tbl%0d_rd", i),  bus.rd_data,         tbl[i].rd);
         chk($sformatf("tbl%0d_cnt", i), 128'(bus.count),     128'(tbl[i].cnt));
         chk($sformatf("tbl%0d_emp", i), 128'(bus.empty),     128'(tbl[i].emp));
         chk($sformatf("tbl%0d_ful", i), 128'(bus.full),      128'(tbl[i].ful));
         chk($sformatf("tbl%0d_ovf", i), 128'(bus.overflow),  128'(tbl[i].ovf));
         chk($sformatf("tbl%0d_udf", i), 128'(bus.underflow), 128'(tbl[i].udf));
      end

      // Fill to full, overflow, drain in order.
      cyc(0, 0, 0, '0);
      for (int i = 0; i < 16; i++) cyc(1, 1, 0, 128'(i));
      chk("fill_full", 128'(bus.full),  128'h1);
      chk("fill_cnt",  128'(bus.count), 128'd16);
      cyc(1, 1, 0, 128'hFF);
      chk("ovf_pulse", 128'(bus.overflow), 128'h1);
      chk("ovf_cnt",   128'(bus.count),    128'd16);
      for (int i = 0; i < 16; i++) begin
         cyc(1, 0, 1, '0);
         chk("drain", bus.rd_data, 128'(i));
      end
      chk("drain_empty", 128'(bus.empty), 128'h1);

      // Wrap-around, then push+pop while full.
      cyc(0, 0, 0, '0);
      for (int i = 0; i < 10; i++) cyc(1, 1, 0, 128'(200 + i));
      for (int i = 0; i < 10; i++) cyc(1, 0, 1, '0);
      for (int i = 0; i < 16; i++) cyc(1, 1, 0, 128'(100 + i));
      chk("wrap_full", 128'(bus.full), 128'h1);
      cyc(1, 1, 1, 128'hA5);
      chk("sim_rd",   bus.rd_data,         128'd100);
      chk("sim_cnt",  128'(bus.count),     128'd16);
      chk("sim_full", 128'(bus.full),      128'h1);
      chk("sim_ovf",  128'(bus.overflow),  128'h0);
      for (int i = 1; i < 16; i++) begin
         cyc(1, 0, 1, '0);
         chk("wrap_rd", bus.rd_data, 128'(100 + i));
      end
      cyc(1, 0, 1, '0);
      chk("a5_last", bus.rd_data, 128'hA5);

      // Underflow and mid-operation reset.
      cyc(1, 0, 1, '0);
      chk("udf_pulse", 128'(bus.underflow), 128'h1);
      chk("udf_hold",  bus.rd_data,         128'hA5);
      cyc(1, 0, 0, '0);
      chk("udf_one",   128'(bus.underflow), 128'h0);
      for (int i = 0; i < 5; i++) cyc(1, 1, 0, 128'(300 + i));
      cyc(0, 0, 0, '0);
      chk("mrst_cnt",   128'(bus.count), 128'h0);
      chk("mrst_empty", 128'(bus.empty), 128'h1);
      cyc(1, 0, 1, '0);
      chk("mrst_udf", 128'(bus.underflow), 128'h1);

      // Random traffic with shifting bias so both full and empty occur.
      for (int i = 0; i < 3000; i++) begin
         if (i % 500 == 0) begin
            wp = $urandom_range(20, 90);
            rp = $urandom_range(20, 90);
         end
         cyc($urandom_range(0, 199) != 0,
             $urandom_range(0, 99) < wp,
             $urandom_range(0, 99) < rp,
             {$urandom, $urandom, $urandom, $urandom});
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
